// File: rtl/mult_sequencer_pkg.sv
// Shared MIPS decode constants and the state encoding of the iterative multiplier.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] MFHI   = 6'h10;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MFLO   = 6'h12;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Handshake and result bundle between the EX/hazard logic (master) and the multiplier (slave).
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic             abort;
    logic             hilo_read_req;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, abort, hilo_read_req, operand_a, operand_b,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, abort, hilo_read_req, operand_a, operand_b,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/mult_sequencer_datapath.sv
// Radix-2 shift-add datapath: operand magnitudes, accumulator/multiplier shift
// pair, the WIDTH+1-bit adder and the final sign correction.
module mult_step_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   operand_a_i,
    input  logic [WIDTH-1:0]   operand_b_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sign_q, sign_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] rawProduct;

    // Next-state of the shift pair: load magnitudes on accept, otherwise one add-and-shift per step.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        if (load_i) begin
            mcand_d  = operand_a_i;
            mplier_d = operand_b_i;
            sign_d   = 1'b0;
            acc_d    = '0;
            if (SIGNED) begin
                if (operand_a_i[WIDTH-1]) mcand_d  = -operand_a_i;
                if (operand_b_i[WIDTH-1]) mplier_d = -operand_b_i;
                sign_d = operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1];
            end
        end else if (step_i) begin
            acc_d    = sum[WIDTH:1];
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        end
    end

    // Shift registers and latched sign, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
        end
    end

    // Unsigned magnitude product, negated modulo 2^(2*WIDTH) when the operand signs differed.
    always_comb begin
        rawProduct = {acc_q, mplier_q};
        product_o  = sign_q ? -rawProduct : rawProduct;
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle MULT/MULTU sequencer owning HI/LO and the stall request to the hazard unit.
module mult_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    mult_sequencer_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_t        state_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               loadEn;
    logic               stepEn;
    logic [2*WIDTH-1:0] product;

    assign loadEn = (state_q == IDLE) && bus.start && !bus.abort;
    assign stepEn = (state_q == RUN);

    mult_step_datapath #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_datapath (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (loadEn),
        .step_i      (stepEn),
        .operand_a_i (bus.operand_a),
        .operand_b_i (bus.operand_b),
        .product_o   (product)
    );

    // Sequencer FSM: accept, count WIDTH steps, commit HI/LO on leaving DONE unless squashed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q <= RUN;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        count_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (!bus.abort) begin
                        hi_q <= product[2*WIDTH-1:WIDTH];
                        lo_q <= product[WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = busy_q && (bus.start || bus.hilo_read_req);

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: signed and unsigned instances, cycle-accurate checks.
module tb_mult_sequencer;

    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset_n;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc         = 0;
    int   doneSeen;

    mult_sequencer_if #(.WIDTH(WIDTH)) ifS ();
    mult_sequencer_if #(.WIDTH(WIDTH)) ifU ();

    mult_sequencer #(.WIDTH(WIDTH), .SIGNED(1'b1)) dutS (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifS.slave)
    );

    mult_sequencer #(.WIDTH(WIDTH), .SIGNED(1'b0)) dutU (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifU.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #2;
        cyc++;
    endtask

    task automatic skipTo(input int n);
        while (cyc < n) nextCycle();
    endtask

    // Present operands with start for one accepting edge; afterwards cyc=1 is the first RUN cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit toS, input bit toU);
        ifS.operand_a = a;
        ifS.operand_b = b;
        ifU.operand_a = a;
        ifU.operand_b = b;
        ifS.start     = toS;
        ifU.start     = toU;
        @(posedge clock);
        #2;
        cyc = 1;
        ifS.start = 1'b0;
        ifU.start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ifS.start = 1'b0; ifS.abort = 1'b0; ifS.hilo_read_req = 1'b0;
        ifS.operand_a = '0; ifS.operand_b = '0;
        ifU.start = 1'b0; ifU.abort = 1'b0; ifU.hilo_read_req = 1'b0;
        ifU.operand_a = '0; ifU.operand_b = '0;
        #1;
        checkOutput("rst_busy",  ifS.busy,  0);
        checkOutput("rst_stall", ifS.stall, 0);
        checkOutput("rst_done",  ifS.done,  0);
        checkOutput("rst_hi",    ifS.hi,    0);
        checkOutput("rst_lo",    ifS.lo,    0);
        checkOutput("rst_u_lo",  ifU.lo,    0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        nextCycle();

        // 1) 3 x 5 signed: done exactly in cycle 33, result from cycle 34
        applyStimulus(32'd3, 32'd5, 1'b1, 1'b0);
        checkOutput("t1_busy_c1", ifS.busy, 1);
        skipTo(32);
        checkOutput("t1_done_c32", ifS.done, 0);
        skipTo(33);
        checkOutput("t1_done_c33", ifS.done, 1);
        checkOutput("t1_lo_hold_c33", ifS.lo, 0);
        skipTo(34);
        checkOutput("t1_done_c34", ifS.done, 0);
        checkOutput("t1_busy_c34", ifS.busy, 0);
        checkOutput("t1_hi", ifS.hi, 32'h00000000);
        checkOutput("t1_lo", ifS.lo, 32'h0000000F);

        // 2) -2 x 3 on both signed and unsigned instances
        applyStimulus(32'hFFFFFFFE, 32'd3, 1'b1, 1'b1);
        skipTo(34);
        checkOutput("t2_s_hi", ifS.hi, 32'hFFFFFFFF);
        checkOutput("t2_s_lo", ifS.lo, 32'hFFFFFFFA);
        checkOutput("t2_u_hi", ifU.hi, 32'h00000002);
        checkOutput("t2_u_lo", ifU.lo, 32'hFFFFFFFA);

        // 3) most-negative squared
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        skipTo(34);
        checkOutput("t3_hi", ifS.hi, 32'h40000000);
        checkOutput("t3_lo", ifS.lo, 32'h00000000);

        // 4) HI/LO reader held from cycle 5
        applyStimulus(32'd7, 32'd9, 1'b1, 1'b0);
        skipTo(4);
        checkOutput("t4_stall_c4", ifS.stall, 0);
        skipTo(5);
        ifS.hilo_read_req = 1'b1;
        #1;
        checkOutput("t4_stall_c5", ifS.stall, 1);
        skipTo(33);
        checkOutput("t4_stall_c33", ifS.stall, 1);
        skipTo(34);
        checkOutput("t4_stall_c34", ifS.stall, 0);
        checkOutput("t4_hi", ifS.hi, 32'h0);
        checkOutput("t4_lo", ifS.lo, 32'h3F);
        ifS.hilo_read_req = 1'b0;

        // 5) back-to-back MULT held upstream while busy
        applyStimulus(32'd100, 32'd200, 1'b1, 1'b0);
        skipTo(10);
        ifS.operand_a = 32'h1234;
        ifS.operand_b = 32'h10;
        ifS.start     = 1'b1;
        #1;
        checkOutput("t5_stall_c10", ifS.stall, 1);
        skipTo(33);
        checkOutput("t5_stall_c33", ifS.stall, 1);
        skipTo(34);
        checkOutput("t5_stall_c34", ifS.stall, 0);
        checkOutput("t5_lo1", ifS.lo, 32'h4E20);
        skipTo(35);
        ifS.start = 1'b0;
        checkOutput("t5_busy_c35", ifS.busy, 1);
        skipTo(67);
        checkOutput("t5_done_c67", ifS.done, 1);
        skipTo(68);
        checkOutput("t5_hi2", ifS.hi, 32'h0);
        checkOutput("t5_lo2", ifS.lo, 32'h12340);

        // 6) abort mid-RUN: no done, HI/LO untouched
        applyStimulus(32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        skipTo(10);
        ifS.abort = 1'b1;
        skipTo(11);
        ifS.abort = 1'b0;
        checkOutput("t6_busy_c11", ifS.busy, 0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifS.done) doneSeen++;
            nextCycle();
        end
        checkOutput("t6_done_never", doneSeen, 0);
        checkOutput("t6_lo_kept", ifS.lo, 32'h12340);

        // abort together with start in IDLE: nothing starts
        ifS.start = 1'b1;
        ifS.abort = 1'b1;
        nextCycle();
        ifS.start = 1'b0;
        ifS.abort = 1'b0;
        checkOutput("t6_abort_wins", ifS.busy, 0);

        // asynchronous reset mid-RUN clears HI/LO immediately
        applyStimulus(32'd3, 32'd5, 1'b1, 1'b0);
        skipTo(10);
        checkOutput("t7_busy_pre", ifS.busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t7_busy_rst", ifS.busy, 0);
        checkOutput("t7_lo_rst",   ifS.lo,   0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // recovery: -1 x -1 signed, 0xFFFFFFFF squared unsigned
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        skipTo(34);
        checkOutput("t8_s_hi", ifS.hi, 32'h00000000);
        checkOutput("t8_s_lo", ifS.lo, 32'h00000001);
        checkOutput("t8_u_hi", ifU.hi, 32'hFFFFFFFE);
        checkOutput("t8_u_lo", ifU.lo, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
